ddr3_init_refresh: RTL and testbench

DDR3_INIT_REFRESH -- requirements
Module: ddr3_init_refresh

---
 rtl/ddr3_pkg.sv | 51 +++++
 rtl/ddr3_refresh_timer.sv | 54 +++++
 rtl/ddr3_init_refresh.sv | 200 ++++++++++++++++++++
 tb/tb_ddr3_init_refresh.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared DDR3 command encodings, controller state enumeration and default timing.
// States ST_ZQCS/ST_ZQCS_WAIT exist only when DDR3_ZQCS_EN is defined.
package ddr3_pkg;

    localparam int CNT_W        = 16;
    localparam int OWED_MAX     = 8;
    localparam int ZQCS_CYC     = 64;
    localparam int ZQCS_REF_CNT = 128;

    localparam int DEF_T_RST_CYC   = 200;
    localparam int DEF_T_CKE_CYC   = 500;
    localparam int DEF_TXPR_CYC    = 96;
    localparam int DEF_TMRD_CYC    = 4;
    localparam int DEF_TMOD_CYC    = 12;
    localparam int DEF_TZQINIT_CYC = 512;
    localparam int DEF_TRFC_CYC    = 88;
    localparam int DEF_TREFI_CYC   = 3120;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQC = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [3:0] {
        ST_RST_WAIT,
        ST_CKE_WAIT,
        ST_XPR_WAIT,
        ST_MRS2,
        ST_MRS3,
        ST_MRS1,
        ST_MRS0,
        ST_ZQCL,
        ST_ZQ_WAIT,
        ST_IDLE,
        ST_REF,
`ifdef DDR3_ZQCS_EN
        ST_RFC_WAIT,
        ST_ZQCS,
        ST_ZQCS_WAIT
`else
        ST_RFC_WAIT
`endif
    } state_e;

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Refresh interval timer plus saturating count of owed refreshes.
module ddr3_refresh_timer
    import ddr3_pkg::*;
#(
    parameter int TREFI_CYC = DEF_TREFI_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dec,
    output logic [3:0] owed,
    output logic       urgent
);

    localparam int TW = $clog2(TREFI_CYC + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    owed_q, owed_d;
    logic          tick;

    // Counts TREFI_CYC..1 so expiries are exactly TREFI_CYC cycles apart.
    always_comb begin
        tmr_d  = tmr_q;
        tick   = 1'b0;
        if (run) begin
            if (tmr_q <= TW'(1)) begin
                tmr_d = TW'(TREFI_CYC);
                tick  = 1'b1;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
        end
        owed_d = owed_q;
        if (tick && !dec) begin
            if (owed_q != 4'(OWED_MAX)) owed_d = owed_q + 4'd1;
        end else if (dec && !tick && owed_q != 4'd0) begin
            owed_d = owed_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q  <= TW'(TREFI_CYC);
            owed_q <= 4'd0;
        end else begin
            tmr_q  <= tmr_d;
            owed_q <= owed_d;
        end
    end

    assign owed   = owed_q;
    assign urgent = (owed_q == 4'(OWED_MAX));

endmodule

// File: rtl/ddr3_init_refresh.sv
// DDR3 power-up init sequencer and periodic refresh scheduler.
// Define DDR3_ZQCS_EN for a ZQ short calibration after every 128 refreshes.
module ddr3_init_refresh
    import ddr3_pkg::*;
#(
    parameter int T_RST_CYC   = DEF_T_RST_CYC,
    parameter int T_CKE_CYC   = DEF_T_CKE_CYC,
    parameter int TXPR_CYC    = DEF_TXPR_CYC,
    parameter int TMRD_CYC    = DEF_TMRD_CYC,
    parameter int TMOD_CYC    = DEF_TMOD_CYC,
    parameter int TZQINIT_CYC = DEF_TZQINIT_CYC,
    parameter int TRFC_CYC    = DEF_TRFC_CYC,
    parameter int TREFI_CYC   = DEF_TREFI_CYC,
    parameter int ADDR_W      = 14,
    parameter int BA_W        = 3,
    parameter logic [ADDR_W-1:0] MR0_VAL = ADDR_W'(14'h0512),
    parameter logic [ADDR_W-1:0] MR1_VAL = '0,
    parameter logic [ADDR_W-1:0] MR2_VAL = '0,
    parameter logic [ADDR_W-1:0] MR3_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              RST_N,
    output logic              CKE,
    output logic [2:0]        cmd,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr,
    output logic              init_done,
    output logic              ref_req,
    input  logic              ref_gnt,
    output logic              ref_urgent
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fst_q, fst_d;
    logic             init_done_q, init_done_d;
    logic [3:0]       owed;
    logic             ref_dec;

    assign ref_req = (state_q == ST_IDLE) && (owed != 4'd0);
    assign ref_dec = ref_req && ref_gnt;

    ddr3_refresh_timer #(
        .TREFI_CYC (TREFI_CYC)
    ) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (init_done_q),
        .dec    (ref_dec),
        .owed   (owed),
        .urgent (ref_urgent)
    );

`ifdef DDR3_ZQCS_EN
    localparam int RCW = $clog2(ZQCS_REF_CNT);

    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
    logic           zq_pend_q, zq_pend_d;
    logic           zqcs_go;

    assign zqcs_go = (state_q == ST_IDLE) && !ref_dec && zq_pend_q && ref_gnt;

    always_comb begin
        ref_cnt_d = ref_cnt_q;
        zq_pend_d = zq_pend_q;
        if (ref_dec) begin
            ref_cnt_d = ref_cnt_q + RCW'(1);
            if (ref_cnt_q == RCW'(ZQCS_REF_CNT - 1)) zq_pend_d = 1'b1;
        end
        if (zqcs_go) zq_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            zq_pend_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            zq_pend_q <= zq_pend_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        case (state_q)
            ST_RST_WAIT: if (cnt_q == '0) begin
                state_d = ST_CKE_WAIT;
                cnt_d   = CNT_W'(T_CKE_CYC);
            end
            ST_CKE_WAIT: if (cnt_q == '0) begin
                state_d = ST_XPR_WAIT;
                cnt_d   = CNT_W'(TXPR_CYC);
            end
            ST_XPR_WAIT: if (cnt_q == '0) begin
                state_d = ST_MRS2;
                cnt_d   = CNT_W'(TMRD_CYC);
            end
            ST_MRS2: if (cnt_q == '0) begin
                state_d = ST_MRS3;
                cnt_d   = CNT_W'(TMRD_CYC);
            end
            ST_MRS3: if (cnt_q == '0) begin
                state_d = ST_MRS1;
                cnt_d   = CNT_W'(TMRD_CYC);
            end
            ST_MRS1: if (cnt_q == '0) begin
                state_d = ST_MRS0;
                cnt_d   = CNT_W'(TMOD_CYC);
            end
            ST_MRS0: if (cnt_q == '0) state_d = ST_ZQCL;
            ST_ZQCL: begin
                state_d = ST_ZQ_WAIT;
                cnt_d   = CNT_W'(TZQINIT_CYC);
            end
            ST_ZQ_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
            ST_IDLE: begin
                if (ref_dec) state_d = ST_REF;
`ifdef DDR3_ZQCS_EN
                else if (zqcs_go) state_d = ST_ZQCS;
`endif
            end
            // tRFC is measured from the REF command, so REF plus RFC_WAIT spans TRFC_CYC+1 cycles.
            ST_REF: begin
                state_d = ST_RFC_WAIT;
                cnt_d   = CNT_W'(TRFC_CYC - 1);
            end
            ST_RFC_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
`ifdef DDR3_ZQCS_EN
            ST_ZQCS: begin
                state_d = ST_ZQCS_WAIT;
                cnt_d   = CNT_W'(ZQCS_CYC);
            end
            ST_ZQCS_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
`endif
            default: state_d = ST_RST_WAIT;
        endcase
        fst_d       = (state_d != state_q);
        init_done_d = init_done_q || (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST_WAIT;
            cnt_q       <= CNT_W'(T_RST_CYC);
            fst_q       <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fst_q       <= fst_d;
            init_done_q <= init_done_d;
        end
    end

    // MRS states hold for their whole tMRD/tMOD wait; the command goes out on the first cycle only.
    always_comb begin
        cmd  = CMD_NOP;
        ba   = '0;
        addr = '0;
        case (state_q)
            ST_MRS2: if (fst_q) begin
                cmd  = CMD_MRS;
                ba   = BA_W'(2);
                addr = MR2_VAL;
            end
            ST_MRS3: if (fst_q) begin
                cmd  = CMD_MRS;
                ba   = BA_W'(3);
                addr = MR3_VAL;
            end
            ST_MRS1: if (fst_q) begin
                cmd  = CMD_MRS;
                ba   = BA_W'(1);
                addr = MR1_VAL;
            end
            ST_MRS0: if (fst_q) begin
                cmd  = CMD_MRS;
                ba   = BA_W'(0);
                addr = MR0_VAL;
            end
            ST_ZQCL: begin
                cmd      = CMD_ZQC;
                addr[10] = 1'b1;
            end
            ST_REF: cmd = CMD_REF;
`ifdef DDR3_ZQCS_EN
            ST_ZQCS: cmd = CMD_ZQC;
`endif
            default: ;
        endcase
    end

    assign RST_N     = (state_q != ST_RST_WAIT);
    assign CKE       = (state_q != ST_RST_WAIT) && (state_q != ST_CKE_WAIT);
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ddr3_init_refresh.sv
// Bench for ddr3_init_refresh: init command table plus a cycle model of refresh scheduling.
module tb_ddr3_init_refresh;

    localparam int T_RST = 4, T_CKE = 6, TXPR = 5, TMRD = 4, TMOD = 6, TZQ = 16;
    localparam int TRFC = 5, TREFI = 20, ZQCS_BUSY = 66;
    localparam logic [13:0] MR0 = 14'h0512, MR1 = 14'h0044, MR2 = 14'h0008, MR3 = 14'h0004;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_ZQC = 3'b110, C_NOP = 3'b111;

    logic        clk = 1'b0, rst_n = 1'b1, ref_gnt = 1'b0;
    logic        RST_N, CKE, init_done, ref_req, ref_urgent;
    logic [2:0]  cmd, ba;
    logic [13:0] addr;

    int checks = 0, errors = 0;
    int ecnt;

    typedef struct {int t; logic [2:0] c; logic [2:0] b; logic [13:0] a;} ev_t;
    typedef struct {string nm; int t; logic [2:0] c; logic [2:0] b; logic [13:0] a;} ivec_t;

    ev_t log_q[$];
    int  ref_t[$];
    int  t_rstn, t_cke, t_done, n_ref, n_zqcs;
    bit  cke_drop;

    // reference model state
    int         m_I, m_owed, m_busy, m_refs, m_zqn;
    bit         m_pend;
    logic [2:0] m_cmd;

    ddr3_init_refresh #(
        .T_RST_CYC(T_RST), .T_CKE_CYC(T_CKE), .TXPR_CYC(TXPR), .TMRD_CYC(TMRD),
        .TMOD_CYC(TMOD), .TZQINIT_CYC(TZQ), .TRFC_CYC(TRFC), .TREFI_CYC(TREFI),
        .ADDR_W(14), .BA_W(3),
        .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .RST_N(RST_N), .CKE(CKE), .cmd(cmd), .ba(ba),
        .addr(addr), .init_done(init_done), .ref_req(ref_req), .ref_gnt(ref_gnt),
        .ref_urgent(ref_urgent)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (RST_N && t_rstn < 0) t_rstn = ecnt;
            if (CKE && t_cke < 0) t_cke = ecnt;
            if (init_done && t_done < 0) t_done = ecnt;
            if (t_cke >= 0 && !CKE) cke_drop = 1'b1;
            if (cmd != C_NOP) log_q.push_back('{ecnt, cmd, ba, addr});
            if (cmd == C_REF) begin n_ref++; ref_t.push_back(ecnt); end
            if (cmd == C_ZQC && !addr[10]) n_zqcs++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        log_q.delete(); ref_t.delete();
        t_rstn = -1; t_cke = -1; t_done = -1; n_ref = 0; n_zqcs = 0; cke_drop = 1'b0;
        #1;
        chk("rst RST_N", RST_N, 0);
        chk("rst CKE", CKE, 0);
        chk("rst cmd", cmd, C_NOP);
        chk("rst ba", ba, 0);
        chk("rst addr", addr, 0);
        chk("rst init_done", init_done, 0);
        chk("rst ref_req", ref_req, 0);
        chk("rst ref_urgent", ref_urgent, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_init();
        ivec_t tbl[5];
        int t_mrs2, t_mrs3, t_mrs1, t_mrs0, t_zq, t_idle, g;
        t_mrs2 = (T_RST + 1) + (T_CKE + 1) + (TXPR + 1);
        t_mrs3 = t_mrs2 + TMRD + 1;
        t_mrs1 = t_mrs3 + TMRD + 1;
        t_mrs0 = t_mrs1 + TMRD + 1;
        t_zq   = t_mrs0 + TMOD + 1;
        t_idle = t_zq + 1 + TZQ + 1;
        tbl[0] = '{"mrs2", t_mrs2, C_MRS, 3'd2, MR2};
        tbl[1] = '{"mrs3", t_mrs3, C_MRS, 3'd3, MR3};
        tbl[2] = '{"mrs1", t_mrs1, C_MRS, 3'd1, MR1};
        tbl[3] = '{"mrs0", t_mrs0, C_MRS, 3'd0, MR0};
        tbl[4] = '{"zqcl", t_zq,   C_ZQC, 3'd0, 14'h0400};
        g = 0;
        while (!init_done && g < 1000) begin
            @(negedge clk); #1;
            g++;
        end
        chk("init_done reached", init_done, 1);
        chk("RST_N rise cycle", t_rstn, T_RST + 1);
        chk("CKE rise cycle", t_cke, T_RST + 1 + T_CKE + 1);
        chk("init_done cycle", t_done, t_idle);
        chk("init cmd count", log_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                chk({tbl[i].nm, " cycle"}, log_q[i].t, tbl[i].t);
                chk({tbl[i].nm, " cmd"},   log_q[i].c, tbl[i].c);
                chk({tbl[i].nm, " ba"},    log_q[i].b, tbl[i].b);
                chk({tbl[i].nm, " addr"},  log_q[i].a, tbl[i].a);
            end
        end
        m_I = t_idle; m_owed = 0; m_busy = 0; m_refs = 0; m_zqn = 0; m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit g, input int e);
        bit iss, zq, tick;
        iss = (m_owed > 0) && (m_busy == 0) && g;
        zq  = 1'b0;
`ifdef DDR3_ZQCS_EN
        zq  = !iss && (m_busy == 0) && m_pend && g;
`endif
        tick = (e > m_I) && ((e - m_I) % TREFI == 0);
        if (tick && !iss)      m_owed = (m_owed < 8) ? m_owed + 1 : 8;
        else if (iss && !tick) m_owed = m_owed - 1;
        if (iss)             m_busy = TRFC + 1;
        else if (zq)         m_busy = ZQCS_BUSY;
        else if (m_busy > 0) m_busy = m_busy - 1;
        if (iss) begin
            m_refs++;
            if (m_refs % 128 == 0) m_pend = 1'b1;
        end
        if (zq) begin m_pend = 1'b0; m_zqn++; end
        m_cmd = iss ? C_REF : (zq ? C_ZQC : C_NOP);
    endtask

    // mode 0: grant low, 1: grant high, 2: random grant
    task automatic run_cycles(input int n, input int mode);
        bit g, er, eu;
        int e;
        for (int i = 0; i < n; i++) begin
            g = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            ref_gnt = g;
            e = ecnt + 1;
            @(posedge clk);
            model_edge(g, e);
            @(negedge clk); #1;
            er = (m_owed > 0) && (m_busy == 0);
            eu = (m_owed == 8);
            chk("refresh {req,urg,cmd,a10}", {ref_req, ref_urgent, cmd, addr[10]},
                {er, eu, m_cmd, 1'b0});
        end
    endtask

    initial begin
        int g;
        apply_reset();
        run_init();

        run_cycles(6 * TREFI, 1);
        chk("steady refs", n_ref, m_refs);

        run_cycles(10 * TREFI, 0);
        chk("starved urgent", ref_urgent, 1);
        chk("starved req", ref_req, 1);
        ref_t.delete();
        run_cycles(8 * (TRFC + 2) + 2, 1);
        chk("burst ref count >= 8", ref_t.size() >= 8, 1);
        if (ref_t.size() >= 8)
            for (int i = 1; i < 8; i++) chk("burst spacing", ref_t[i] - ref_t[i-1], TRFC + 2);

        run_cycles(300, 2);

        g = 0;
        while (cmd !== C_REF && g < 100) begin run_cycles(1, 1); g++; end
        chk("ref before reset", cmd, C_REF);
        run_cycles(2, 1);
        apply_reset();
        run_init();

        g = 0;
        while (m_refs < 130 && g < 4000) begin run_cycles(1, 1); g++; end
        run_cycles(80, 1);
        chk("total refs", n_ref, m_refs);
        chk("zqcs count", n_zqcs, m_zqn);
        chk("cke stayed high", cke_drop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
